// File: rtl/score_display_pkg.sv
// Shared types and segment encoding for the multiplexed score display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package score_display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
        logic [7:0] code;
        case (nibble)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result held valid
// while done_o is high, saturated to all nines when it does not fit DIGITS.
module bin2bcd_seq
    import score_display_pkg::*;
#(
    parameter int SCORE_W = 10,
    parameter int DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [SCORE_W-1:0]    bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int ACC_W = 4 * DIGITS + 4;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    conv_state_e        state_q;
    logic [SCORE_W-1:0] shift_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_adj;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;

    for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
        assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? (acc_q[4*gi +: 4] + 4'd3)
                                                             : acc_q[4*gi +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        shift_q <= bin_i;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q   <= {acc_adj[ACC_W-2:0], shift_q[SCORE_W-1]};
                    // A bit falling off the guard nibble means the score is far too large.
                    ovf_q   <= ovf_q | acc_adj[ACC_W-1];
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = (state_q == DONE);
    assign bcd_o  = (ovf_q || (acc_q[ACC_W-1 -: 4] != 4'd0)) ? {DIGITS{4'h9}}
                                                             : acc_q[4*DIGITS-1:0];

endmodule

// File: rtl/score_display_mux.sv
// Multi-digit 7-segment score driver: continuous BCD conversion plus digit scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the top nonzero digit.
module score_display_mux
    import score_display_pkg::*;
#(
    parameter int SCORE_W  = 10,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SCORE_W-1:0]  i_score,
    output logic                o_busy,
    output logic [7:0]          o_segment,
    output logic [DIGITS-1:0]   o_segment_an
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                conv_done;
    logic [4*DIGITS-1:0] conv_bcd;

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (1'b1),
        .bin_i   (i_score),
        .busy_o  (o_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    logic [4*DIGITS-1:0] disp_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [7:0]          seg_q;
    logic [7:0]          seg_d;
    logic [DIGITS-1:0]   an_q;
    logic [DIGITS-1:0]   an_d;
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   blank_vec;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib[gi] = disp_q[4*gi +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit 0 always shows, so a zero score still displays a single "0".
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
        end else begin : g_upper
            assign blank_vec[gi] = (disp_q[4*DIGITS-1:4*gi] == '0);
        end
    end
`else
    assign blank_vec = '0;
`endif

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = blank_vec[idx_q] ? SEG_BLANK : seg_decode(nib[idx_q]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            seg_q  <= SEG_BLANK;
            an_q   <= '1;
        end else begin
            if (conv_done) begin
                disp_q <= conv_bcd;
            end
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign o_segment    = seg_q;
    assign o_segment_an = an_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench: arithmetic display model compared every cycle, plus
// hand-computed digit expectations and a saturating 3-digit instance.
module tb_score_display_mux;

    localparam int W   = 10;
    localparam int D   = 4;
    localparam int SD  = 4;
    localparam int W2  = 14;
    localparam int D2  = 3;
    localparam int HSZ = 4096;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  score;
    logic          busy;
    logic [7:0]    seg;
    logic [D-1:0]  an;
    logic [W2-1:0] score2;
    logic          busy2;
    logic [7:0]    seg2;
    logic [D2-1:0] an2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    score_display_mux #(.SCORE_W(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_score      (score),
        .o_busy       (busy),
        .o_segment    (seg),
        .o_segment_an (an)
    );

    score_display_mux #(.SCORE_W(W2), .DIGITS(D2), .SCAN_DIV(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .i_score      (score2),
        .o_busy       (busy2),
        .o_segment    (seg2),
        .o_segment_an (an2)
    );

    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;  default: return 8'hFF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: conversions sample the score every W+2 cycles from the first
    // cycle after reset and land in the display W+1 cycles after sampling;
    // the digit index advances every SD cycles.
    int          e = 0;
    int          hist [HSZ];
    int          mdisp = 0;
    bit          model_ready = 1'b0;
    logic [7:0]  exp_seg;
    logic [D-1:0] exp_an;
    logic        exp_busy;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                e        = 0;
                mdisp    = 0;
                exp_seg  = 8'hFF;
                exp_an   = '1;
                exp_busy = 1'b0;
            end else begin
                int idx, dig, p, v;
                bit blank;
                e++;
                hist[e % HSZ] = int'(score);
                idx   = ((e - 1) / SD) % D;
                dig   = (mdisp / pow10(idx)) % 10;
                blank = LZB && (idx > 0) && (mdisp < pow10(idx));
                exp_seg = blank ? 8'hFF : seg_of(dig);
                exp_an  = ~(D'(1) << idx);
                p = (e - 1) % (W + 2);
                if (p == W + 1) begin
                    v = hist[(e - W - 1) % HSZ];
                    mdisp = (v > pow10(D) - 1) ? pow10(D) - 1 : v;
                end
                exp_busy = (p < W);
            end
            model_ready = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                check("cyc_an", 32'(an), 32'(exp_an));
                check("cyc_seg", 32'(seg), 32'(exp_seg));
                check("cyc_busy", 32'(busy), 32'(exp_busy));
            end
        end
    end

    task automatic wait_an(input logic [D-1:0] pat, input string name);
        int n = 0;
        while (an !== pat && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(an), 32'(pat));
    endtask

    task automatic wait_an2(input logic [D2-1:0] pat, input string name);
        int n = 0;
        while (an2 !== pat && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(an2), 32'(pat));
    endtask

    task automatic show4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3, input string tag);
        wait_an(4'hE, {tag, "_an0"}); check({tag, "_d0"}, 32'(seg), 32'(s0));
        wait_an(4'hD, {tag, "_an1"}); check({tag, "_d1"}, 32'(seg), 32'(s1));
        wait_an(4'hB, {tag, "_an2"}); check({tag, "_d2"}, 32'(seg), 32'(s2));
        wait_an(4'h7, {tag, "_an3"}); check({tag, "_d3"}, 32'(seg), 32'(s3));
        $display("show %s: digits checked", tag);
    endtask

    task automatic show3(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input string tag);
        wait_an2(3'b110, {tag, "_an0"}); check({tag, "_d0"}, 32'(seg2), 32'(s0));
        wait_an2(3'b101, {tag, "_an1"}); check({tag, "_d1"}, 32'(seg2), 32'(s1));
        wait_an2(3'b011, {tag, "_an2"}); check({tag, "_d2"}, 32'(seg2), 32'(s2));
        $display("show %s: digits checked", tag);
    endtask

    initial begin
        logic [7:0] lead;
        int n;
        lead   = LZB ? 8'hFF : 8'hC0;
        rst    = 1'b1;
        score  = 10'd1023;
        score2 = 14'd1500;

        // Reset held three cycles, then release.
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h0FF);
        check("rst_an", 32'(an), 32'h00F);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_an", 32'(an), 32'h00E);
        check("first_seg", 32'(seg), 32'h0C0);
        $display("reset release: first cycle checked");
        repeat (W + 4) @(negedge clk);
        show4(8'hB0, 8'hA4, 8'hC0, 8'hF9, "score1023");

        // Saturation on the 3-digit instance, already converted by now.
        show3(8'h90, 8'h90, 8'h90, "sat1500");

        // Leading-zero handling.
        score = 10'd12;
        repeat (2 * (W + 2)) @(negedge clk);
        show4(8'hA4, 8'hF9, lead, lead, "score12");

        // Score change while a conversion is shifting.
        score = 10'd2;
        repeat (2 * (W + 2)) @(negedge clk);
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("busy_seen", 32'(busy), 32'h1);
        repeat (3) @(negedge clk);
        score = 10'd12;
        @(negedge clk);
        check("busy_hold", 32'(busy), 32'h1);
        repeat (2 * (W + 2)) @(negedge clk);
        show4(8'hA4, 8'hF9, lead, lead, "mid12");

        score2 = 14'd998;
        score  = 10'd1023;
        repeat (2 * (W2 + 2)) @(negedge clk);
        show3(8'h80, 8'h90, 8'h90, "d2_998");
        score2 = 14'd1000;
        repeat (2 * (W2 + 2)) @(negedge clk);
        show3(8'h90, 8'h90, 8'h90, "sat1000");

        // Reset while digit 2 is lit.
        wait_an(4'hB, "pre_rst_an");
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_seg", 32'(seg), 32'h0FF);
        check("mid_rst_an", 32'(an), 32'h00F);
        rst = 1'b0;
        @(negedge clk);
        check("rerel_an", 32'(an), 32'h00E);
        check("rerel_seg", 32'(seg), 32'h0C0);
        repeat (W + 4) @(negedge clk);
        show4(8'hB0, 8'hA4, 8'hC0, 8'hF9, "reconv1023");

        // Anode dwell time.
        wait_an(4'hD, "dwell_pre");
        wait_an(4'hE, "dwell_start");
        n = 0;
        while (an === 4'hE && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("dwell_len", 32'(n), 32'd4);
        $display("anode dwell: %0d cycles", n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
